// File: rtl/cv32e40p_obi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40p_obi_pkg
// Description : Shared types and bounds for the instruction OBI responder.
// Revision    : 1.0 - initial release
// ============================================================================
package cv32e40p_obi_pkg;

    localparam int unsigned c_MAX_OUTSTANDING_BOUND = 4;
    localparam int unsigned c_CNT_W                 = 3;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [3:0]  delay;
    } rsp_entry_t;

    typedef enum logic [0:0] {
        ST_READY = 1'b0,
        ST_STALL = 1'b1
    } stall_state_t;

endpackage
`default_nettype wire

// File: rtl/cv32e40p_obi_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40p_obi_rsp_fifo
// Description : In-order OBI response queue with per-entry delay countdown.
// Revision    : 1.0 - initial release
// ============================================================================
module cv32e40p_obi_rsp_fifo
    import cv32e40p_obi_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_push,
    input  logic               i_push_err,
    input  logic [3:0]         i_push_delay,
    input  logic [31:0]        i_mem_rdata,
    output logic               o_rvalid,
    output logic [31:0]        o_rdata,
    output logic               o_err,
    output logic [c_CNT_W-1:0] o_count
);

    rsp_entry_t         r_entry [c_MAX_OUTSTANDING_BOUND];
    logic [1:0]         r_wr_ptr;
    logic [1:0]         r_rd_ptr;
    logic [1:0]         r_cap_idx;
    logic               r_cap_pend;
    logic [c_CNT_W-1:0] r_count;
    rsp_entry_t         w_head;
    logic               w_pop;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (32'(p) == DEPTH - 1) ? 2'd0 : p + 2'd1;
    endfunction

    assign w_head   = r_entry[r_rd_ptr];
    assign w_pop    = (r_count != '0) && (w_head.delay == 4'd0);
    assign o_rvalid = w_pop;
    assign o_err    = w_pop & w_head.err;
    assign o_count  = r_count;

    // A zero-delay head is returned in the same cycle its memory data arrives.
    always_comb begin
        o_rdata = 32'h0;
        if (w_pop && !w_head.err) begin
            o_rdata = (r_cap_pend && (r_cap_idx == r_rd_ptr)) ? i_mem_rdata : w_head.rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_MAX_OUTSTANDING_BOUND; i++) begin
                r_entry[i] <= '0;
            end
            r_wr_ptr   <= 2'd0;
            r_rd_ptr   <= 2'd0;
            r_cap_idx  <= 2'd0;
            r_cap_pend <= 1'b0;
            r_count    <= '0;
        end else begin
            for (int i = 0; i < c_MAX_OUTSTANDING_BOUND; i++) begin
                if (r_entry[i].delay != 4'd0) begin
                    r_entry[i].delay <= r_entry[i].delay - 4'd1;
                end
            end
            if (r_cap_pend && !r_entry[r_cap_idx].err) begin
                r_entry[r_cap_idx].rdata <= i_mem_rdata;
            end
            if (i_push) begin
                r_entry[r_wr_ptr] <= '{rdata: 32'h0, err: i_push_err, delay: i_push_delay};
                r_wr_ptr          <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_cap_pend <= i_push;
            r_cap_idx  <= r_wr_ptr;
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/cv32e40p_instr_obi_responder.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40p_instr_obi_responder
// Description : OBI instruction-fetch responder backed by a synchronous memory.
// Revision    : 1.0 - initial release
// ============================================================================
module cv32e40p_instr_obi_responder
    import cv32e40p_obi_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] MEM_BASE        = 32'h0000_0000,
    parameter int unsigned MEM_AW          = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_req_i,
    input  logic [31:0]       instr_addr_i,
    output logic              instr_gnt_o,
    output logic              instr_rvalid_o,
    output logic [31:0]       instr_rdata_o,
    output logic              instr_err_o,
    output logic              mem_req_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    input  logic [31:0]       mem_rdata_i,
    input  logic [3:0]        cfg_gnt_stall_i,
    input  logic [3:0]        cfg_rsp_delay_i,
    output logic              busy_o
);

    // Window bounds are held in 33 bits so a window ending at 4 GiB does not wrap.
    localparam logic [32:0]        c_WIN_LO  = {1'b0, MEM_BASE};
    localparam logic [32:0]        c_WIN_HI  = c_WIN_LO + (33'd4 << MEM_AW);
    localparam logic [c_CNT_W-1:0] c_MAX_CNT = c_CNT_W'(MAX_OUTSTANDING);

    stall_state_t       r_state;
    logic [3:0]         r_stall_cnt;
    logic [c_CNT_W-1:0] w_count;
    logic               w_in_range;
    logic [31:0]        w_offset;

    assign w_in_range  = ({1'b0, instr_addr_i} >= c_WIN_LO) && ({1'b0, instr_addr_i} < c_WIN_HI);
    assign w_offset    = instr_addr_i - MEM_BASE;
    assign instr_gnt_o = instr_req_i && !rst && (w_count < c_MAX_CNT) && (r_stall_cnt == 4'd0);
    assign mem_req_o   = instr_gnt_o && w_in_range;
    assign mem_addr_o  = mem_req_o ? MEM_AW'(w_offset >> 2) : '0;
    assign busy_o      = (w_count != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_READY;
            r_stall_cnt <= 4'd0;
        end else begin
            case (r_state)
                ST_READY: begin
                    if (instr_gnt_o && (cfg_gnt_stall_i != 4'd0)) begin
                        r_stall_cnt <= cfg_gnt_stall_i;
                        r_state     <= ST_STALL;
                    end
                end
                ST_STALL: begin
                    r_stall_cnt <= r_stall_cnt - 4'd1;
                    if (r_stall_cnt == 4'd1) begin
                        r_state <= ST_READY;
                    end
                end
                default: begin
                    r_state     <= ST_READY;
                    r_stall_cnt <= 4'd0;
                end
            endcase
        end
    end

    cv32e40p_obi_rsp_fifo #(
        .DEPTH(MAX_OUTSTANDING)
    ) u_rsp_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (instr_gnt_o),
        .i_push_err  (!w_in_range),
        .i_push_delay(cfg_rsp_delay_i),
        .i_mem_rdata (mem_rdata_i),
        .o_rvalid    (instr_rvalid_o),
        .o_rdata     (instr_rdata_o),
        .o_err       (instr_err_o),
        .o_count     (w_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_cv32e40p_instr_obi_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_cv32e40p_instr_obi_responder
// Description : Directed and randomised checks of the instruction OBI responder.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cv32e40p_instr_obi_responder;

    localparam int unsigned MAX_OUT = 2;
    localparam logic [31:0] BASE    = 32'h0001_0000;
    localparam int unsigned AW      = 12;
    localparam logic [31:0] WIN     = 32'h0000_4000;

    logic          clk = 1'b0;
    logic          rst;
    logic          instr_req_i;
    logic [31:0]   instr_addr_i;
    logic          instr_gnt_o;
    logic          instr_rvalid_o;
    logic [31:0]   instr_rdata_o;
    logic          instr_err_o;
    logic          mem_req_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_rdata_i;
    logic [3:0]    cfg_gnt_stall_i;
    logic [3:0]    cfg_rsp_delay_i;
    logic          busy_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cv32e40p_instr_obi_responder #(
        .MAX_OUTSTANDING(MAX_OUT),
        .MEM_BASE       (BASE),
        .MEM_AW         (AW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .instr_req_i    (instr_req_i),
        .instr_addr_i   (instr_addr_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .instr_err_o    (instr_err_o),
        .mem_req_o      (mem_req_o),
        .mem_addr_o     (mem_addr_o),
        .mem_rdata_i    (mem_rdata_i),
        .cfg_gnt_stall_i(cfg_gnt_stall_i),
        .cfg_rsp_delay_i(cfg_rsp_delay_i),
        .busy_o         (busy_o)
    );

    function automatic logic [31:0] memf(input logic [31:0] w);
        return (w * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    // Synchronous memory; returns junk when not read so bypass bugs show up.
    always @(posedge clk) begin
        mem_rdata_i <= mem_req_o ? memf(32'(mem_addr_o)) : 32'hDEAD_BEEF;
    end

    task automatic drive(input logic req, input logic [31:0] addr,
                         input logic [3:0] stall, input logic [3:0] dly);
        @(posedge clk);
        #1;
        instr_req_i     = req;
        instr_addr_i    = addr;
        cfg_gnt_stall_i = stall;
        cfg_rsp_delay_i = dly;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 32'h0, 4'd0, 4'd0);
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        rst = 1'b1; instr_req_i = 1'b1; instr_addr_i = BASE + 32'h8;
        cfg_gnt_stall_i = 4'd0; cfg_rsp_delay_i = 4'd0;
        @(negedge clk);
        n_cmp++;
        if ({instr_gnt_o, instr_rvalid_o, instr_err_o, mem_req_o, busy_o} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got gnt/rv/err/mreq/busy=%b want 00000",
                     {instr_gnt_o, instr_rvalid_o, instr_err_o, mem_req_o, busy_o});
        end
        n_cmp++;
        if (instr_rdata_o !== 32'h0 || mem_addr_o !== '0) begin
            n_err++;
            $display("FAIL reset_data: got rdata=%h maddr=%h want 0/0", instr_rdata_o, mem_addr_o);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (instr_gnt_o !== 1'b1 || mem_req_o !== 1'b1 || mem_addr_o !== 12'd2) begin
            n_err++;
            $display("FAIL reset_first_gnt: got gnt=%b mreq=%b maddr=%h want 1/1/002",
                     instr_gnt_o, mem_req_o, mem_addr_o);
        end
        drive(1'b0, 32'h0, 4'd0, 4'd0);
        n_cmp++;
        if (instr_rvalid_o !== 1'b1 || instr_rdata_o !== memf(2) || instr_err_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_first_rsp: got rv=%b rdata=%h err=%b want 1/%h/0",
                     instr_rvalid_o, instr_rdata_o, instr_err_o, memf(2));
        end
        drive(1'b0, 32'h0, 4'd0, 4'd0);
        n_cmp++;
        if (instr_rvalid_o !== 1'b0 || busy_o !== 1'b0 || instr_rdata_o !== 32'h0) begin
            n_err++;
            $display("FAIL reset_idle: got rv=%b busy=%b rdata=%h want 0/0/0",
                     instr_rvalid_o, busy_o, instr_rdata_o);
        end
    endtask

    task automatic test_back_to_back();
        logic        eg, ev;
        logic [31:0] ed;
        for (int i = 0; i < 5; i++) begin
            eg = (i < 3);
            ev = (i >= 1 && i <= 3);
            ed = ev ? memf(32'(i - 1)) : 32'h0;
            drive(eg, BASE + 32'(4 * i), 4'd0, 4'd0);
            n_cmp++;
            if (instr_gnt_o !== eg) begin
                n_err++;
                $display("FAIL b2b_gnt cyc=%0d: got %b want %b", i, instr_gnt_o, eg);
            end
            n_cmp++;
            if (instr_rvalid_o !== ev || instr_rdata_o !== ed || instr_err_o !== 1'b0) begin
                n_err++;
                $display("FAIL b2b_rsp cyc=%0d: got rv=%b rdata=%h err=%b want %b/%h/0",
                         i, instr_rvalid_o, instr_rdata_o, instr_err_o, ev, ed);
            end
        end
    endtask

    task automatic test_depth();
        logic [10:0] gt = 11'b000_0010_0011;
        logic [10:0] rt = 11'b010_0011_0000;
        int          ng = 0;
        int          nr = 0;
        for (int i = 0; i < 11; i++) begin
            drive(i <= 5, BASE + 32'(4 * (12 + ng)), 4'd0, 4'd3);
            n_cmp++;
            if (instr_gnt_o !== gt[i]) begin
                n_err++;
                $display("FAIL depth_gnt cyc=%0d: got %b want %b", i, instr_gnt_o, gt[i]);
            end
            n_cmp++;
            if (instr_rvalid_o !== rt[i] ||
                (rt[i] && instr_rdata_o !== memf(32'(12 + nr)))) begin
                n_err++;
                $display("FAIL depth_rsp cyc=%0d: got rv=%b rdata=%h want rv=%b rdata=%h",
                         i, instr_rvalid_o, instr_rdata_o, rt[i], memf(32'(12 + nr)));
            end
            if (gt[i]) ng++;
            if (rt[i]) nr++;
        end
    endtask

    task automatic test_stall();
        logic [10:0] gt = 11'b000_0100_1001;
        logic [10:0] rt = 11'b010_0100_1000;
        logic [10:0] bt = 11'b011_1111_1110;
        int          ng = 0;
        int          nr = 0;
        for (int i = 0; i < 11; i++) begin
            drive(i <= 8, BASE + 32'(4 * (20 + ng)), 4'd2, 4'd2);
            n_cmp++;
            if (instr_gnt_o !== gt[i] || busy_o !== bt[i]) begin
                n_err++;
                $display("FAIL stall_gnt_busy cyc=%0d: got gnt=%b busy=%b want %b/%b",
                         i, instr_gnt_o, busy_o, gt[i], bt[i]);
            end
            n_cmp++;
            if (instr_rvalid_o !== rt[i] ||
                (rt[i] && instr_rdata_o !== memf(32'(20 + nr)))) begin
                n_err++;
                $display("FAIL stall_rsp cyc=%0d: got rv=%b rdata=%h want rv=%b rdata=%h",
                         i, instr_rvalid_o, instr_rdata_o, rt[i], memf(32'(20 + nr)));
            end
            if (gt[i]) ng++;
            if (rt[i]) nr++;
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] addrs [4];
        logic [31:0] edat  [4];
        logic        eerr  [4];
        logic        emreq [4];
        addrs = '{BASE + 32'h80, BASE + WIN, BASE + 32'h84, BASE - 32'h4};
        edat  = '{memf(32), 32'h0, memf(33), 32'h0};
        eerr  = '{1'b0, 1'b1, 1'b0, 1'b1};
        emreq = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            drive(i < 4, (i < 4) ? addrs[i] : 32'h0, 4'd0, 4'd0);
            if (i < 4) begin
                n_cmp++;
                if (instr_gnt_o !== 1'b1 || mem_req_o !== emreq[i] ||
                    (emreq[i] && mem_addr_o !== 12'(32 + i / 2))) begin
                    n_err++;
                    $display("FAIL oor_req cyc=%0d: got gnt=%b mreq=%b maddr=%h want 1/%b",
                             i, instr_gnt_o, mem_req_o, mem_addr_o, emreq[i]);
                end
            end
            if (i >= 1) begin
                n_cmp++;
                if (instr_rvalid_o !== 1'b1 || instr_rdata_o !== edat[i-1] ||
                    instr_err_o !== eerr[i-1]) begin
                    n_err++;
                    $display("FAIL oor_rsp cyc=%0d: got rv=%b rdata=%h err=%b want 1/%h/%b",
                             i, instr_rvalid_o, instr_rdata_o, instr_err_o, edat[i-1], eerr[i-1]);
                end
            end
        end
    endtask

    task automatic test_mixed_delay();
        logic [7:0] rt = 8'b0110_0000;
        int         nr = 0;
        for (int i = 0; i < 8; i++) begin
            drive(i < 2, BASE + 32'(4 * (40 + i)), 4'd0, (i == 0) ? 4'd4 : 4'd0);
            if (i < 2) begin
                n_cmp++;
                if (instr_gnt_o !== 1'b1) begin
                    n_err++;
                    $display("FAIL mixed_gnt cyc=%0d: got %b want 1", i, instr_gnt_o);
                end
            end
            n_cmp++;
            if (instr_rvalid_o !== rt[i] ||
                (rt[i] && instr_rdata_o !== memf(32'(40 + nr)))) begin
                n_err++;
                $display("FAIL mixed_rsp cyc=%0d: got rv=%b rdata=%h want rv=%b rdata=%h",
                         i, instr_rvalid_o, instr_rdata_o, rt[i], memf(32'(40 + nr)));
            end
            if (rt[i]) nr++;
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, BASE + 32'h0C8, 4'd0, 4'd5);
        drive(1'b1, BASE + 32'h0CC, 4'd0, 4'd5);
        @(posedge clk);
        #1;
        rst = 1'b1; instr_req_i = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy_o !== 1'b0 || instr_rvalid_o !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_clear: got busy=%b rv=%b want 0/0", busy_o, instr_rvalid_o);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 32'h0, 4'd0, 4'd0);
            n_cmp++;
            if (instr_rvalid_o !== 1'b0) begin
                n_err++;
                $display("FAIL midrst_stale cyc=%0d: got rv=%b want 0", i, instr_rvalid_o);
            end
        end
        drive(1'b1, BASE + 32'h10, 4'd0, 4'd0);
        n_cmp++;
        if (instr_gnt_o !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_gnt: got %b want 1", instr_gnt_o);
        end
        drive(1'b0, 32'h0, 4'd0, 4'd0);
        n_cmp++;
        if (instr_rvalid_o !== 1'b1 || instr_rdata_o !== memf(4) || instr_err_o !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_rsp: got rv=%b rdata=%h err=%b want 1/%h/0",
                     instr_rvalid_o, instr_rdata_o, instr_err_o, memf(4));
        end
    endtask

    typedef struct {
        int          ready;
        logic        err;
        logic [31:0] data;
    } rsp_t;

    // Reference: pending responses with absolute ready cycles, one retired per cycle.
    task automatic test_random();
        rsp_t q[$];
        int   stall_until = -1;
        for (int c = 0; c < 600; c++) begin
            logic        req, inr, eg, ev, ee;
            logic [31:0] addr, ed;
            logic [3:0]  st, dl;
            req = (c < 570) && ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 7))
                0:       addr = BASE + WIN + 32'($urandom_range(0, 255));
                1:       addr = BASE - 32'($urandom_range(1, 64));
                default: addr = BASE + 32'($urandom_range(0, 32'h3FFF));
            endcase
            st = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 3)) : 4'd0;
            dl = 4'($urandom_range(0, 5));
            drive(req, addr, st, dl);
            inr = (addr >= BASE) && ((addr - BASE) < WIN);
            eg  = req && (q.size() < MAX_OUT) && (c > stall_until);
            ev  = 1'b0;
            ee  = 1'b0;
            ed  = 32'h0;
            if (q.size() > 0) begin
                if (q[0].ready <= c) begin
                    ev = 1'b1;
                    ee = q[0].err;
                    ed = q[0].data;
                end
            end
            n_cmp++;
            if (instr_gnt_o !== eg || busy_o !== (q.size() != 0)) begin
                n_err++;
                $display("FAIL rand_gnt cyc=%0d: got gnt=%b busy=%b want %b/%b",
                         c, instr_gnt_o, busy_o, eg, q.size() != 0);
            end
            n_cmp++;
            if (mem_req_o !== (eg && inr) ||
                mem_addr_o !== ((eg && inr) ? 12'((addr - BASE) >> 2) : 12'h0)) begin
                n_err++;
                $display("FAIL rand_mem cyc=%0d: got mreq=%b maddr=%h addr=%h want mreq=%b",
                         c, mem_req_o, mem_addr_o, addr, eg && inr);
            end
            n_cmp++;
            if (instr_rvalid_o !== ev || instr_rdata_o !== ed || instr_err_o !== ee) begin
                n_err++;
                $display("FAIL rand_rsp cyc=%0d: got rv=%b rdata=%h err=%b want %b/%h/%b",
                         c, instr_rvalid_o, instr_rdata_o, instr_err_o, ev, ed, ee);
            end
            if (ev) void'(q.pop_front());
            if (eg) begin
                q.push_back('{c + 1 + int'(dl), !inr, inr ? memf((addr - BASE) >> 2) : 32'h0});
                if (st != 4'd0) stall_until = c + int'(st);
            end
        end
        n_cmp++;
        if (q.size() != 0 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL rand_drain: got busy=%b pending=%0d want 0/0", busy_o, q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst             = 1'b1;
        instr_req_i     = 1'b0;
        instr_addr_i    = 32'h0;
        cfg_gnt_stall_i = 4'd0;
        cfg_rsp_delay_i = 4'd0;
        repeat (2) @(posedge clk);
        test_reset();
        test_back_to_back();
        idle(4);
        test_depth();
        idle(4);
        test_stall();
        idle(4);
        test_out_of_range();
        idle(4);
        test_mixed_delay();
        idle(4);
        test_reset_mid();
        idle(4);
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
